// File: rtl/chacha_job_sequencer.sv
// -----------------------------------------------------------------------------
// chacha_job_sequencer
// Bus master that runs complete ChaCha20-Poly1305 jobs on the crypto core on
// behalf of NUM_REQ requesters. A round-robin arbiter picks a requester, its
// key/nonce/data are latched, the core is programmed (key, nonce, data, INIT),
// the status register is polled for the data-valid and tag-valid bits, and the
// output block and tag are returned with the requester ID on a valid/ready port.
//
// Optional feature macro: CHACHA_SEQ_KEY_CACHE_EN
//   When defined, the last programmed key is remembered with a valid flag and
//   the key programming phase is skipped for a job that reuses that key.
//   The cache is cleared by reset and by any poll timeout.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o per-requester job request / one-cycle accept pulse
//   req_key_i/nonce_i/data_i  packed per-requester job operands
//   rsp_valid_o/ready_i result handshake; rsp_id_o/data_o/tag_o/err_o payload
//   busy_o              high whenever the sequencer is not idle
//   m_cs_o/we_o/addr_o/wdata_o, m_rdata_i   core register bus (2-cycle access)
// -----------------------------------------------------------------------------
module chacha_job_sequencer #(
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = 1,
    parameter int POLL_LIMIT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*256-1:0] req_key_i,
    input  logic [NUM_REQ*96-1:0]  req_nonce_i,
    input  logic [NUM_REQ*512-1:0] req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [511:0]           rsp_data_o,
    output logic [127:0]           rsp_tag_o,
    output logic                   rsp_err_o,
    output logic                   busy_o,
    output logic                   m_cs_o,
    output logic                   m_we_o,
    output logic [7:0]             m_addr_o,
    output logic [511:0]           m_wdata_o,
    input  logic [511:0]           m_rdata_i
);

    localparam int CNT_W = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_WR_KEY, S_WR_NONCE, S_WR_DATA, S_WR_INIT,
        S_POLL_V, S_RD_DATA, S_POLL_T, S_RD_TAG, S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                phase_q, phase_d;      // 0 = issue cycle, 1 = gap cycle
    logic [2:0]          idx_q, idx_d;          // word index inside multi-write phases
    logic [CNT_W-1:0]    cnt_q, cnt_d;          // status reads in current poll phase
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic [255:0]        key_q, key_d;
    logic [95:0]         nonce_q, nonce_d;
    logic [511:0]        data_q, data_d;
    logic [511:0]        rsp_data_q, rsp_data_d;
    logic [127:0]        rsp_tag_q, rsp_tag_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                m_cs_q, m_cs_d, m_we_q, m_we_d;
    logic [7:0]          m_addr_q, m_addr_d;
    logic [511:0]        m_wdata_q, m_wdata_d;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
    logic [255:0]        cache_key_q, cache_key_d;
    logic                cache_vld_q, cache_vld_d;
`endif

    logic                arb_hit_s;
    logic [ID_W-1:0]     arb_sel_s, arb_nxt_s;
    logic [255:0]        key_sel_s, key_sh_s;
    logic [95:0]         nonce_sel_s, nonce_sh_s;
    logic [511:0]        data_sel_s;

    // Round-robin pick: first pass from the pointer upward, second pass wraps to 0.
    always_comb begin
        arb_hit_s   = 1'b0;
        arb_sel_s   = '0;
        key_sel_s   = '0;
        nonce_sel_s = '0;
        data_sel_s  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!arb_hit_s && req_valid_i[r] && (r >= int'(rr_q))) begin
                arb_hit_s = 1'b1;
                arb_sel_s = ID_W'(r);
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!arb_hit_s && req_valid_i[r]) begin
                arb_hit_s = 1'b1;
                arb_sel_s = ID_W'(r);
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == arb_sel_s) begin
                key_sel_s   = req_key_i[256*r +: 256];
                nonce_sel_s = req_nonce_i[96*r +: 96];
                data_sel_s  = req_data_i[512*r +: 512];
            end else begin
                key_sel_s   = key_sel_s;
            end
        end
        if (int'(arb_sel_s) >= NUM_REQ - 1) begin
            arb_nxt_s = '0;
        end else begin
            arb_nxt_s = arb_sel_s + ID_W'(1);
        end
    end

    // Sequencer next-state, operand latching and result capture.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = '0;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Grant is decided here so the accept pulse is a flop during ARB.
                if (arb_hit_s) begin
                    state_d     = S_ARB;
                    gnt_d       = arb_sel_s;
                    rr_d        = arb_nxt_s;
                    key_d       = key_sel_s;
                    nonce_d     = nonce_sel_s;
                    data_d      = data_sel_s;
                    req_ready_d = NUM_REQ'(1) << arb_sel_s;
                    rsp_data_d  = '0;
                    rsp_tag_d   = '0;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                phase_d = 1'b0;
                idx_d   = 3'd0;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
                if (cache_vld_q && (cache_key_q == key_q)) begin
                    state_d = S_WR_NONCE;
                end else begin
                    state_d = S_WR_KEY;
                end
`else
                state_d = S_WR_KEY;
`endif
            end
            S_WR_KEY: begin
                phase_d = ~phase_q;
                if (phase_q && (idx_q == 3'd7)) begin
                    idx_d   = 3'd0;
                    state_d = S_WR_NONCE;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
                    cache_key_d = key_q;
                    cache_vld_d = 1'b1;
`endif
                end else if (phase_q) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_WR_NONCE: begin
                phase_d = ~phase_q;
                if (phase_q && (idx_q == 3'd2)) begin
                    idx_d   = 3'd0;
                    state_d = S_WR_DATA;
                end else if (phase_q) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_WR_DATA: begin
                phase_d = ~phase_q;
                state_d = phase_q ? S_WR_INIT : S_WR_DATA;
            end
            S_WR_INIT: begin
                phase_d = ~phase_q;
                cnt_d   = '0;
                state_d = phase_q ? S_POLL_V : S_WR_INIT;
            end
            S_POLL_V, S_POLL_T: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((state_q == S_POLL_V) ? m_rdata_i[1] : m_rdata_i[2]) begin
                        state_d = (state_q == S_POLL_V) ? S_RD_DATA : S_RD_TAG;
                    end else if ((cnt_q + CNT_W'(1)) == CNT_W'(POLL_LIMIT)) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        rsp_tag_d  = '0;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
                        cache_vld_d = 1'b0;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RD_DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    rsp_data_d = m_rdata_i;
                    cnt_d      = '0;
                    state_d    = S_POLL_T;
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_TAG: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    rsp_tag_d = m_rdata_i[127:0];
                    state_d   = S_RESP;
                end else begin
                    state_d = S_RD_TAG;
                end
            end
            S_RESP: begin
                phase_d = 1'b0;
                state_d = (rsp_valid_q && rsp_ready_i) ? S_IDLE : S_RESP;
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    // Bus and status outputs derived from the next state so they leave on flops.
    always_comb begin
        m_cs_d      = 1'b0;
        m_we_d      = 1'b0;
        m_addr_d    = 8'h00;
        m_wdata_d   = '0;
        key_sh_s    = key_q >> (8'd224 - {idx_d, 5'd0});
        nonce_sh_s  = nonce_q >> (8'd64 - {idx_d, 5'd0});
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        if (!phase_d) begin
            case (state_d)
                S_WR_KEY:   begin m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = 8'h10 + {5'd0, idx_d};
                                  m_wdata_d = {480'd0, key_sh_s[31:0]}; end
                S_WR_NONCE: begin m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = 8'h20 + {5'd0, idx_d};
                                  m_wdata_d = {480'd0, nonce_sh_s[31:0]}; end
                S_WR_DATA:  begin m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = 8'h30; m_wdata_d = data_q; end
                S_WR_INIT:  begin m_cs_d = 1'b1; m_we_d = 1'b1; m_addr_d = 8'h08; m_wdata_d = 512'h1; end
                S_POLL_V, S_POLL_T: begin m_cs_d = 1'b1; m_addr_d = 8'h09; end
                S_RD_DATA:  begin m_cs_d = 1'b1; m_addr_d = 8'h30; end
                S_RD_TAG:   begin m_cs_d = 1'b1; m_addr_d = 8'h40; end
                default:    begin m_cs_d = 1'b0; end
            endcase
        end else begin
            m_cs_d = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;  phase_q <= 1'b0;  idx_q <= 3'd0;  cnt_q <= '0;
            rr_q <= '0;  gnt_q <= '0;  key_q <= '0;  nonce_q <= '0;  data_q <= '0;
            rsp_data_q <= '0;  rsp_tag_q <= '0;  rsp_err_q <= 1'b0;  rsp_valid_q <= 1'b0;
            req_ready_q <= '0;  busy_q <= 1'b0;
            m_cs_q <= 1'b0;  m_we_q <= 1'b0;  m_addr_q <= 8'h00;  m_wdata_q <= '0;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
            cache_key_q <= '0;  cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  phase_q <= phase_d;  idx_q <= idx_d;  cnt_q <= cnt_d;
            rr_q <= rr_d;  gnt_q <= gnt_d;  key_q <= key_d;  nonce_q <= nonce_d;  data_q <= data_d;
            rsp_data_q <= rsp_data_d;  rsp_tag_q <= rsp_tag_d;  rsp_err_q <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;  req_ready_q <= req_ready_d;  busy_q <= busy_d;
            m_cs_q <= m_cs_d;  m_we_q <= m_we_d;  m_addr_q <= m_addr_d;  m_wdata_q <= m_wdata_d;
`ifdef CHACHA_SEQ_KEY_CACHE_EN
            cache_key_q <= cache_key_d;  cache_vld_q <= cache_vld_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = gnt_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign m_cs_o      = m_cs_q;
    assign m_we_o      = m_we_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;

endmodule

// File: tb/tb_chacha_job_sequencer.sv
module tb_chacha_job_sequencer;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*256-1:0] req_key;
    logic [NUM_REQ*96-1:0]  req_nonce;
    logic [NUM_REQ*512-1:0] req_data;
    logic                   rsp_valid, rsp_ready, rsp_err, busy;
    logic [ID_W-1:0]        rsp_id;
    logic [511:0]           rsp_data;
    logic [127:0]           rsp_tag;
    logic                   m_cs, m_we;
    logic [7:0]             m_addr;
    logic [511:0]           m_wdata, m_rdata;

    always #5 clk = ~clk;

    chacha_job_sequencer #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .POLL_LIMIT(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_key_i(req_key), .req_nonce_i(req_nonce), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_data_o(rsp_data), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err), .busy_o(busy),
        .m_cs_o(m_cs), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Core model: logs every access, status bits rise 5 / 15 cycles after INIT.
    logic [8:0]   log_q[$];
    logic [31:0]  mk0 = '0, mk7 = '0, mn0 = '0, mn1 = '0, mn2 = '0;
    logic [511:0] md = '0;
    int           cyc = 0, init_cyc = 0;
    bit           init_seen = 1'b0, never_v = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_cs) begin
            log_q.push_back({m_we, m_addr});
            if (m_we) begin
                case (m_addr)
                    8'h10: mk0 = m_wdata[31:0];
                    8'h17: mk7 = m_wdata[31:0];
                    8'h20: mn0 = m_wdata[31:0];
                    8'h21: mn1 = m_wdata[31:0];
                    8'h22: mn2 = m_wdata[31:0];
                    8'h30: md  = m_wdata;
                    8'h08: begin init_seen = 1'b1; init_cyc = cyc; end
                    default: ;
                endcase
            end else begin
                case (m_addr)
                    8'h09: m_rdata = {509'd0,
                                      init_seen && (cyc - init_cyc >= 15),
                                      init_seen && !never_v && (cyc - init_cyc >= 5), 1'b0};
                    8'h30: m_rdata = md ^ {16{mk0}};
                    8'h40: m_rdata = {384'd0, mn0, mn1, mn2, mk7};
                    default: m_rdata = '0;
                endcase
            end
        end
    end

    function automatic int count_log(input logic [8:0] lo, input logic [8:0] hi);
        int n = 0;
        foreach (log_q[i]) if (log_q[i] >= lo && log_q[i] <= hi) n++;
        return n;
    endfunction

    task automatic wait_ready(output int g);
        g = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (|req_ready) begin
                g = req_ready[1] ? 1 : 0;
                break;
            end
        end
        if (g < 0) begin
            total++; bad++;
            $display("FAIL wait_ready: no req_ready within 50 cycles");
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL wait_rsp: no rsp_valid within 3000 cycles");
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_job(input int rid, input logic [255:0] k, input logic [95:0] n,
                          input logic [511:0] d, output int lat);
        int g;
        log_q.delete();
        req_key[rid*256 +: 256] = k;
        req_nonce[rid*96 +: 96] = n;
        req_data[rid*512 +: 512] = d;
        req_valid[rid] = 1'b1;
        wait_ready(g);
        req_valid[rid] = 1'b0;
        chk("grant", 512'(g), 512'(rid));
        wait_rsp(lat);
    endtask

    typedef struct {
        int           rid;
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [511:0] data;
        logic [511:0] exp_data;
        logic [127:0] exp_tag;
    } vec_t;

    vec_t        vecs[3];
    logic [7:0]  exp_wr[13];
    logic [255:0] kc;

    initial begin
        int lat, lat1, lat2, g, w;
        bit ok, ok_bus, ok_rdy;
        logic [511:0] snap_d;
        logic [127:0] snap_t;

        vecs[0] = '{0, 256'h00112233_44556677_8899aabb_ccddeeff_0f1e2d3c_4b5a6978_fedcba98_76543210,
                    96'h11111111_22222222_33333333, {16{32'hdeadbeef}}, {16{32'hdebc9cdc}},
                    {32'h11111111, 32'h22222222, 32'h33333333, 32'h76543210}};
        vecs[1] = '{1, {32'hffffffff, 192'd0, 32'h0000000a},
                    96'haaaaaaaa_bbbbbbbb_cccccccc, {16{32'h12345678}}, {16{32'hedcba987}},
                    {32'haaaaaaaa, 32'hbbbbbbbb, 32'hcccccccc, 32'h0000000a}};
        vecs[2] = '{0, {32'h0f0f0f0f, 192'h1, 32'h00000005},
                    96'h00000001_00000002_00000003, {16{32'hf0f0f0f0}}, {16{32'hffffffff}},
                    {32'h00000001, 32'h00000002, 32'h00000003, 32'h00000005}};
        exp_wr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                   8'h20, 8'h21, 8'h22, 8'h30, 8'h08};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_key = '0; req_nonce = '0; req_data = '0; m_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_cs", 512'(m_cs), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_rsp_valid", 512'(rsp_valid), 512'd0);
        chk("rst_req_ready", 512'(req_ready), 512'd0);
        rst = 1'b0;

        // Reset during key programming abandons the job
        req_key[255:0] = vecs[0].key;
        req_valid = 2'b01;
        wait_ready(g);
        req_valid = 2'b00;
        for (int n = 0; n < 50; n++) begin
            if (m_cs && m_we && m_addr == 8'h12) break;
            @(negedge clk);
        end
        chk("mid_in_wr_key", 512'(m_cs && m_we && m_addr == 8'h12), 512'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_m_cs", 512'(m_cs), 512'd0);
        chk("midrst_busy", 512'(busy), 512'd0);
        chk("midrst_rsp_valid", 512'(rsp_valid), 512'd0);
        chk("midrst_req_ready", 512'(req_ready), 512'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || busy || m_cs) ok = 1'b0;
        end
        chk("midrst_quiet", 512'(ok), 512'd1);

        // Table-driven single jobs
        foreach (vecs[i]) begin
            do_job(vecs[i].rid, vecs[i].key, vecs[i].nonce, vecs[i].data, lat);
            chk("rsp_id", 512'(rsp_id), 512'(vecs[i].rid));
            chk("rsp_data", rsp_data, vecs[i].exp_data);
            chk("rsp_tag", 512'(rsp_tag), 512'(vecs[i].exp_tag));
            chk("rsp_err", 512'(rsp_err), 512'd0);
            ok = 1'b1; w = 0;
            foreach (log_q[j]) begin
                if (log_q[j][8]) begin
                    if (w >= 13 || log_q[j][7:0] != exp_wr[w]) ok = 1'b0;
                    w++;
                end
            end
            chk("wr_order", 512'(ok && w == 13), 512'd1);
            accept();
        end

        // Both requesters held: strict alternation from a fresh pointer
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ready(g);
            chk("rr_grant", 512'(g), 512'(j % 2));
            wait_rsp(lat);
            chk("rr_rsp_id", 512'(rsp_id), 512'(j % 2));
            if (j == 3) req_valid = 2'b00;
            accept();
        end

        // Status bit1 never set: exactly 64 polls then error response
        never_v = 1'b1;
        do_job(1, vecs[1].key, vecs[1].nonce, vecs[1].data, lat);
        chk("to_poll_count", 512'(count_log(9'h009, 9'h009)), 512'd64);
        chk("to_no_rd_data", 512'(count_log(9'h030, 9'h030)), 512'd0);
        chk("to_err", 512'(rsp_err), 512'd1);
        chk("to_data", rsp_data, 512'd0);
        chk("to_tag", 512'(rsp_tag), 512'd0);
        chk("to_id", 512'(rsp_id), 512'd1);
        accept();
        never_v = 1'b0;

        // Response held 20 cycles with both requesters pending
        do_job(0, vecs[0].key, vecs[0].nonce, vecs[0].data, lat);
        snap_d = rsp_data; snap_t = rsp_tag;
        chk("hold_data_ok", snap_d, vecs[0].exp_data);
        req_valid = 2'b11;
        ok = 1'b1; ok_bus = 1'b1; ok_rdy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== snap_d || rsp_tag !== snap_t || rsp_id !== 1'b0) ok = 1'b0;
            if (m_cs) ok_bus = 1'b0;
            if (|req_ready) ok_rdy = 1'b0;
        end
        chk("hold_stable", 512'(ok), 512'd1);
        chk("hold_no_bus", 512'(ok_bus), 512'd1);
        chk("hold_no_ready", 512'(ok_rdy), 512'd1);
        req_valid = 2'b00;
        accept();
        repeat (3) @(negedge clk);
        chk("idle_after_resp", 512'(busy), 512'd0);

`ifdef CHACHA_SEQ_KEY_CACHE_EN
        // Repeated key skips programming; a timeout forces it again
        kc = {8{32'hc0ffee01}};
        do_job(0, kc, vecs[0].nonce, vecs[0].data, lat1);
        chk("cache_first_key_wr", 512'(count_log(9'h110, 9'h117)), 512'd8);
        accept();
        do_job(0, kc, vecs[0].nonce, vecs[0].data, lat2);
        chk("cache_hit_key_wr", 512'(count_log(9'h110, 9'h117)), 512'd0);
        chk("cache_hit_lat", 512'(lat2), 512'(lat1 - 16));
        chk("cache_hit_data", rsp_data, vecs[0].data ^ {16{32'hc0ffee01}});
        accept();
        never_v = 1'b1;
        do_job(1, kc, vecs[0].nonce, vecs[0].data, lat);
        chk("cache_to_err", 512'(rsp_err), 512'd1);
        accept();
        never_v = 1'b0;
        do_job(0, kc, vecs[0].nonce, vecs[0].data, lat);
        chk("cache_after_to_key_wr", 512'(count_log(9'h110, 9'h117)), 512'd8);
        accept();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
